// File: rtl/script_pkg.sv
// Shared definitions for the script executor: opcode values, FSM state
// encoding, instruction field positions and the wait-length helper.
package script_pkg;

  // Instruction field positions: op in the low bits, immediate in the high byte.
  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 2;
  localparam int IMM_LSB = 8;
  localparam int IMM_MSB = 15;

  // Opcodes; 3'd5..3'd7 are illegal.
  localparam logic [2:0] OP_END     = 3'd0;
  localparam logic [2:0] OP_SEND    = 3'd1;
  localparam logic [2:0] OP_WAIT_T  = 3'd2;
  localparam logic [2:0] OP_WAIT_FB = 3'd3;
  localparam logic [2:0] OP_JUMP    = 3'd4;

  // Byte placed on the UART path when the script has nothing to send.
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  // Width of the WAIT_T down-counter.
  localparam int TIMER_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_T  = 3'd4,
    ST_WAIT_FB = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  function automatic logic [2:0] instr_op(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [7:0] instr_imm(input logic [15:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

  // Clock cycles for a WAIT_T of imm ticks; 255 * 1536 fits easily in 24 bits.
  function automatic logic [TIMER_W-1:0] wait_cycles(input logic [7:0] imm,
                                                     input int unsigned tick);
    logic [31:0] prod;
    prod = 32'(imm) * 32'(tick);
    return prod[TIMER_W-1:0];
  endfunction

endpackage

// File: rtl/script_executor_if.sv
// Script-memory and UART byte-stream signals of the script executor.
// master: the executor (drives pc and dataIn_bits); slave: its environment.
interface script_executor_if;
  logic [15:0] script;
  logic [7:0]  pc;
  logic        dataOut_valid;
  logic [7:0]  dataOut_bits;
  logic        dataIn_ready;
  logic [7:0]  manual_bits;
  logic [7:0]  dataIn_bits;

  modport master (
    input  script, dataOut_valid, dataOut_bits, dataIn_ready, manual_bits,
    output pc, dataIn_bits
  );

  modport slave (
    output script, dataOut_valid, dataOut_bits, dataIn_ready, manual_bits,
    input  pc, dataIn_bits
  );
endinterface

// File: rtl/script_timer.sv
// Loadable 24-bit down-counter used by the WAIT_T instruction. last_o flags
// the final cycle of a wait so the FSM leaves exactly when the count hits 0.
module script_timer
  import script_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o,
  output logic               last_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear beats load beats decrement; the counter never wraps below 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign last_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/script_executor.sv
// Script executor: fetches 16-bit instructions from ScriptMem, sends game
// bytes to the UART, waits on timers or feedback bytes, and muxes the
// manual byte onto the UART path whenever no script is running.
module script_executor
  import script_pkg::*;
#(
  parameter int unsigned PC_STEP     = 2,
  parameter int unsigned FETCH_LAT   = 1,
  parameter int unsigned TICK_CYCLES = 1536
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     script_mode,
  script_executor_if.master        bus,
  output logic                     running,
  output logic                     done,
  output logic                     error
);

  localparam logic [7:0] PC_INC = 8'(PC_STEP);
  // A fetch takes at least one cycle even if FETCH_LAT is set to 0.
  localparam logic [7:0] FETCH_LAST = 8'((FETCH_LAT > 1) ? (FETCH_LAT - 1) : 0);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  fb_q, fb_d;
  logic [7:0]  fcnt_q, fcnt_d;

  logic [2:0]  op;
  logic [7:0]  imm;
  logic        halted;

  logic               tmr_clear;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               tmr_last;

  // Reserved instruction bits are intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^bus.script[7:3];

  assign op  = instr_op(bus.script);
  assign imm = instr_imm(bus.script);

  assign halted = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);

  script_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero),
    .last_o     (tmr_last)
  );

  // Next-state logic: abort (script_mode, then stop) > start > normal sequencing.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tx_d      = tx_q;
    fb_d      = fb_q;
    fcnt_d    = fcnt_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;

    if (script_mode || stop) begin
      state_d   = ST_IDLE;
      pc_d      = '0;
      tx_d      = IDLE_BYTE;
      fcnt_d    = '0;
      tmr_clear = 1'b1;
    end else if (start && halted) begin
      state_d   = ST_FETCH;
      pc_d      = '0;
      tx_d      = IDLE_BYTE;
      fcnt_d    = '0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // script becomes valid FETCH_LAT cycles after pc changed.
          if (fcnt_q == FETCH_LAST) begin
            fcnt_d  = '0;
            state_d = ST_EXEC;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end

        ST_EXEC: begin
          case (op)
            OP_END: state_d = ST_DONE;
            OP_SEND: begin
              tx_d    = imm;
              state_d = ST_SEND;
            end
            OP_WAIT_T: begin
              if (imm == 8'h00) begin
                pc_d    = pc_q + PC_INC;
                state_d = ST_FETCH;
              end else begin
                tmr_load = 1'b1;
                tmr_val  = wait_cycles(imm, TICK_CYCLES);
                state_d  = ST_WAIT_T;
              end
            end
            OP_WAIT_FB: begin
              fb_d    = imm;
              state_d = ST_WAIT_FB;
            end
            OP_JUMP: begin
              pc_d    = imm;
              state_d = ST_FETCH;
            end
            // Illegal opcode: pc is left pointing at the faulting instruction.
            default: state_d = ST_ERROR;
          endcase
        end

        ST_SEND: begin
          if (bus.dataIn_ready) begin
            tx_d    = IDLE_BYTE;
            pc_d    = pc_q + PC_INC;
            state_d = ST_FETCH;
          end
        end

        ST_WAIT_T: begin
          tmr_dec = 1'b1;
          // Leave on the edge where the count reaches zero.
          if (tmr_last || tmr_zero) begin
            pc_d    = pc_q + PC_INC;
            state_d = ST_FETCH;
          end
        end

        ST_WAIT_FB: begin
          if (bus.dataOut_valid && (bus.dataOut_bits == fb_q)) begin
            pc_d    = pc_q + PC_INC;
            state_d = ST_FETCH;
          end
        end

        default: ; // IDLE, DONE and ERROR hold until start
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      tx_q    <= IDLE_BYTE;
      fb_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tx_q    <= tx_d;
      fb_q    <= fb_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.dataIn_bits = halted ? bus.manual_bits : tx_q;
  assign running         = !halted;
  assign done            = (state_q == ST_DONE);
  assign error           = (state_q == ST_ERROR);

endmodule

// File: tb/tb_script_executor.sv
// Directed testbench for script_executor with a combinational ScriptMem model
// and a shortened WAIT_T tick of 4 cycles.
module tb_script_executor;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic stop;
  logic script_mode;
  logic running;
  logic done;
  logic error;

  logic [15:0] mem [0:255];

  int n_run  = 0;
  int n_fail = 0;

  script_executor_if bus ();

  assign bus.script = mem[bus.pc];

  script_executor #(
    .PC_STEP     (2),
    .FETCH_LAT   (1),
    .TICK_CYCLES (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .script_mode (script_mode),
    .bus         (bus),
    .running     (running),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Pulse start for one edge; afterwards the executor sits in FETCH at pc 0.
  task automatic start_script();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; script_mode = 1'b0;
    bus.dataOut_valid = 1'b0; bus.dataOut_bits = 8'h00;
    bus.dataIn_ready = 1'b0; bus.manual_bits = 8'h00;
    clear_mem();
    #2;
    n_run++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", bus.pc); end
    n_run++; if (bus.dataIn_bits !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", bus.dataIn_bits); end
    n_run++; if ({running, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {running, done, error}); end
    step(2);
    reset = 1'b0;
    step(1);
    n_run++; if ({running, done, error} !== 3'b000) begin n_fail++; $display("FAIL post_reset_flags: got %b expected 000", {running, done, error}); end
  endtask

  task automatic test_mux();
    bus.manual_bits = 8'h5A;
    #1;
    n_run++; if (bus.dataIn_bits !== 8'h5A) begin n_fail++; $display("FAIL mux_idle: got %0h expected 5a", bus.dataIn_bits); end
    bus.manual_bits = 8'hC3;
    #1;
    n_run++; if (bus.dataIn_bits !== 8'hC3) begin n_fail++; $display("FAIL mux_idle2: got %0h expected c3", bus.dataIn_bits); end
    bus.manual_bits = 8'h5A;
    step(1);
  endtask

  task automatic test_send();
    clear_mem();
    mem[0] = 16'h1201;
    mem[2] = 16'h0000;
    start_script();                                  // FETCH
    n_run++; if (running !== 1'b1) begin n_fail++; $display("FAIL send_running: got %b expected 1", running); end
    n_run++; if (bus.dataIn_bits !== 8'h00) begin n_fail++; $display("FAIL send_fetch_byte: got %0h expected 0", bus.dataIn_bits); end
    step(1);                                         // EXEC
    bus.dataIn_ready = 1'b1;                         // seen in EXEC: must not count
    step(1);                                         // SEND
    bus.dataIn_ready = 1'b0;
    n_run++; if (bus.dataIn_bits !== 8'h12) begin n_fail++; $display("FAIL send_byte: got %0h expected 12", bus.dataIn_bits); end
    step(2);
    n_run++; if (bus.dataIn_bits !== 8'h12) begin n_fail++; $display("FAIL send_hold: got %0h expected 12", bus.dataIn_bits); end
    n_run++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL send_hold_pc: got %0h expected 0", bus.pc); end
    bus.dataIn_ready = 1'b1;
    step(1);                                         // FETCH pc 2
    bus.dataIn_ready = 1'b0;
    n_run++; if (bus.dataIn_bits !== 8'h00) begin n_fail++; $display("FAIL send_cleared: got %0h expected 0", bus.dataIn_bits); end
    n_run++; if (bus.pc !== 8'h02) begin n_fail++; $display("FAIL send_pc: got %0h expected 2", bus.pc); end
    step(2);                                         // EXEC END, then DONE
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL send_done: got %b expected 1", done); end
    n_run++; if (running !== 1'b0) begin n_fail++; $display("FAIL send_not_running: got %b expected 0", running); end
    n_run++; if (bus.dataIn_bits !== 8'h5A) begin n_fail++; $display("FAIL send_manual_back: got %0h expected 5a", bus.dataIn_bits); end
  endtask

  task automatic test_wait_t();
    logic exp_done;
    logic [7:0] exp_pc;
    clear_mem();
    mem[0] = 16'h0302;                               // WAIT 3 ticks = 12 cycles
    mem[2] = 16'h0000;
    start_script();                                  // FETCH
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL waitt_start_clears_done: got %b expected 0", done); end
    step(2);                                         // EXEC, then WAIT_T entry
    for (int k = 1; k <= 14; k++) begin
      step(1);
      exp_done = (k == 14);
      exp_pc   = (k >= 12) ? 8'h02 : 8'h00;
      n_run++; if (done !== exp_done) begin n_fail++; $display("FAIL waitt_done_k%0d: got %b expected %b", k, done, exp_done); end
      n_run++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL waitt_pc_k%0d: got %0h expected %0h", k, bus.pc, exp_pc); end
    end
    // WAIT 0 advances straight from EXEC.
    mem[0] = 16'h0002;
    start_script();                                  // FETCH
    step(2);                                         // EXEC, then FETCH pc 2
    n_run++; if (bus.pc !== 8'h02) begin n_fail++; $display("FAIL wait0_pc: got %0h expected 2", bus.pc); end
    step(2);
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL wait0_done: got %b expected 1", done); end
  endtask

  task automatic test_wait_fb();
    clear_mem();
    mem[0] = 16'h4403;
    mem[2] = 16'h0000;
    start_script();
    step(2);                                         // WAIT_FB
    bus.dataOut_valid = 1'b1; bus.dataOut_bits = 8'h43;
    step(1);
    n_run++; if (bus.pc !== 8'h00 || running !== 1'b1) begin n_fail++; $display("FAIL wfb_wrong_byte: got pc %0h run %b expected pc 0 run 1", bus.pc, running); end
    bus.dataOut_valid = 1'b0; bus.dataOut_bits = 8'h44;
    step(2);
    n_run++; if (bus.pc !== 8'h00 || running !== 1'b1) begin n_fail++; $display("FAIL wfb_not_valid: got pc %0h run %b expected pc 0 run 1", bus.pc, running); end
    bus.dataOut_valid = 1'b1;
    step(1);
    bus.dataOut_valid = 1'b0;
    n_run++; if (bus.pc !== 8'h02) begin n_fail++; $display("FAIL wfb_match_pc: got %0h expected 2", bus.pc); end
    step(2);
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL wfb_done: got %b expected 1", done); end
  endtask

  task automatic test_jump_illegal();
    clear_mem();
    mem[0] = 16'h0604;
    mem[6] = 16'h0007;
    start_script();                                  // FETCH pc 0
    n_run++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL jump_pc0: got %0h expected 0", bus.pc); end
    step(2);                                         // EXEC, then FETCH pc 6
    n_run++; if (bus.pc !== 8'h06) begin n_fail++; $display("FAIL jump_pc6: got %0h expected 6", bus.pc); end
    step(2);                                         // EXEC illegal, then ERROR
    n_run++; if (error !== 1'b1) begin n_fail++; $display("FAIL illegal_error: got %b expected 1", error); end
    n_run++; if (bus.pc !== 8'h06) begin n_fail++; $display("FAIL illegal_pc: got %0h expected 6", bus.pc); end
    n_run++; if (bus.dataIn_bits !== 8'h5A) begin n_fail++; $display("FAIL illegal_manual: got %0h expected 5a", bus.dataIn_bits); end
    start_script();
    n_run++; if (error !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL restart_clears_error: got err %b run %b expected 0 1", error, running); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (running !== 1'b0 || bus.pc !== 8'h00) begin n_fail++; $display("FAIL stop_idle: got run %b pc %0h expected 0 0", running, bus.pc); end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0]    = 16'hFE04;                            // JUMP 0xFE
    mem[8'hFE] = 16'h7701;                           // SEND 0x77
    start_script();
    step(2);
    n_run++; if (bus.pc !== 8'hFE) begin n_fail++; $display("FAIL wrap_jump: got %0h expected fe", bus.pc); end
    step(2);
    n_run++; if (bus.dataIn_bits !== 8'h77) begin n_fail++; $display("FAIL wrap_send: got %0h expected 77", bus.dataIn_bits); end
    bus.dataIn_ready = 1'b1;
    step(1);
    bus.dataIn_ready = 1'b0;
    n_run++; if (bus.pc !== 8'h00 || error !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL wrap_pc: got pc %0h err %b run %b expected 0 0 1", bus.pc, error, running); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_abort();
    clear_mem();
    mem[0] = 16'h1201;
    bus.manual_bits = 8'hA5;
    start_script();
    step(2);                                         // SEND
    n_run++; if (bus.dataIn_bits !== 8'h12) begin n_fail++; $display("FAIL abort_pre_send: got %0h expected 12", bus.dataIn_bits); end
    script_mode = 1'b1;
    step(1);
    n_run++; if (running !== 1'b0 || bus.pc !== 8'h00) begin n_fail++; $display("FAIL abort_idle: got run %b pc %0h expected 0 0", running, bus.pc); end
    n_run++; if (bus.dataIn_bits !== 8'hA5) begin n_fail++; $display("FAIL abort_manual: got %0h expected a5", bus.dataIn_bits); end
    start = 1'b1;                                    // ignored while loading
    step(1);
    start = 1'b0;
    script_mode = 1'b0;
    n_run++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_during_load: got %b expected 0", running); end
    step(1);

    // Asynchronous reset in the middle of a timed wait at pc 4.
    clear_mem();
    mem[0] = 16'h0404;
    mem[4] = 16'h0302;
    bus.manual_bits = 8'h00;
    start_script();
    step(6);                                         // WAIT_T for a few cycles
    n_run++; if (bus.pc !== 8'h04 || running !== 1'b1) begin n_fail++; $display("FAIL prereset_wait: got pc %0h run %b expected 4 1", bus.pc, running); end
    #2;
    reset = 1'b1;
    #1;
    n_run++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL async_reset_pc: got %0h expected 0", bus.pc); end
    n_run++; if ({running, done, error} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 000", {running, done, error}); end
    n_run++; if (bus.dataIn_bits !== 8'h00) begin n_fail++; $display("FAIL async_reset_data: got %0h expected 0", bus.dataIn_bits); end
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_mux();
    test_send();
    test_wait_t();
    test_wait_fb();
    test_jump_illegal();
    test_pc_wrap();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
